// File: rtl/difftest_arch_event_pkg.sv
// rtl/difftest_arch_event_pkg.sv - architectural event payload type and field widths
package difftest_arch_event_pkg;

    localparam int IRQ_W    = 32;
    localparam int EXC_W    = 32;
    localparam int PC_W     = 64;
    localparam int INST_W   = 32;
    localparam int COREID_W = 8;
    localparam int EVT_W    = IRQ_W + EXC_W + PC_W + INST_W;

    typedef struct packed {
        logic [IRQ_W-1:0]  interrupt;
        logic [EXC_W-1:0]  exception;
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } arch_event_t;

    // An interrupt outranks a simultaneous exception, so the exception code is dropped.
    function automatic arch_event_t qualify_event(
        input logic [IRQ_W-1:0]  irq,
        input logic [EXC_W-1:0]  exc,
        input logic [PC_W-1:0]   pc,
        input logic [INST_W-1:0] inst
    );
        arch_event_t ev;
        ev.interrupt = irq;
        ev.exception = (irq != '0) ? '0 : exc;
        ev.pc        = pc;
        ev.inst      = inst;
        return ev;
    endfunction

endpackage

// File: rtl/difftest_arch_event_fifo.sv
// rtl/difftest_arch_event_fifo.sv - DEPTH-entry in-order event queue with wrapping pointers
module difftest_arch_event_fifo
    import difftest_arch_event_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_push,
    input  logic        i_pop,
    input  arch_event_t i_wdata,
    output arch_event_t o_rdata,
    output logic        o_full,
    output logic        o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    arch_event_t   r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rptr];

endmodule

// File: rtl/difftest_arch_event_src.sv
// rtl/difftest_arch_event_src.sv - queues commit-stage trap events for the difftest sink (DIFFTEST_ARCH_EVENT_PERF_EN adds a pop counter)
module difftest_arch_event_src
    import difftest_arch_event_pkg::*;
#(
    parameter int                  DEPTH  = 4,
    parameter logic [COREID_W-1:0] COREID = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                evt_valid,
    output logic                evt_ready,
    input  logic [IRQ_W-1:0]    evt_interrupt,
    input  logic [EXC_W-1:0]    evt_exception,
    input  logic [PC_W-1:0]     evt_pc,
    input  logic [INST_W-1:0]   evt_inst,
    input  logic                sink_ready,
    output logic                enable,
    output logic                io_valid,
    output logic [IRQ_W-1:0]    io_interrupt,
    output logic [EXC_W-1:0]    io_exception,
    output logic [PC_W-1:0]     io_exceptionPC,
    output logic [INST_W-1:0]   io_exceptionInst,
    output logic [COREID_W-1:0] io_coreid
`ifdef DIFFTEST_ARCH_EVENT_PERF_EN
    ,
    output logic [31:0]         perf_evt_cnt
`endif
);

    logic        r_rdy_en;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    arch_event_t w_evt;
    arch_event_t w_head;

    // Holds evt_ready low until the first edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_rdy_en <= 1'b0;
        else        r_rdy_en <= 1'b1;
    end

    assign evt_ready = r_rdy_en && !w_full;
    assign w_accept  = evt_valid && evt_ready;
    assign w_push    = w_accept && ((evt_interrupt != '0) || (evt_exception != '0));
    assign w_pop     = !w_empty && sink_ready;
    assign w_evt     = qualify_event(evt_interrupt, evt_exception, evt_pc, evt_inst);

    difftest_arch_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_evt),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign io_valid         = !w_empty;
    assign enable           = !w_empty;
    assign io_interrupt     = w_empty ? '0 : w_head.interrupt;
    assign io_exception     = w_empty ? '0 : w_head.exception;
    assign io_exceptionPC   = w_empty ? '0 : w_head.pc;
    assign io_exceptionInst = w_empty ? '0 : w_head.inst;
    assign io_coreid        = COREID;

`ifdef DIFFTEST_ARCH_EVENT_PERF_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                  r_perf_cnt <= '0;
        else if (w_pop && (r_perf_cnt != '1))        r_perf_cnt <= r_perf_cnt + 32'd1;
    end

    assign perf_evt_cnt = r_perf_cnt;
`endif

endmodule

// File: doc/difftest_arch_event_src.md
DIFFTEST_ARCH_EVENT_SRC -- requirements
Module: difftest_arch_event_src

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning event FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter COREID, default 0, meaning 8-bit core id driven on io_coreid.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-005 SHALL have port evt_valid, input, 1, meaning commit stage offers an event.
REQ-006 SHALL have port evt_ready, output, 1, meaning event accepted this cycle when high with evt_valid.
REQ-007 SHALL have ports evt_interrupt / evt_exception / evt_pc / evt_inst, input, 32/32/64/32, meaning event payload.
REQ-008 SHALL have port sink_ready, input, 1, meaning the difftest sink can take an event this cycle.
REQ-009 SHALL have ports enable and io_valid, output, 1 each, meaning an event is presented to the sink.
REQ-010 SHALL have ports io_interrupt / io_exception / io_exceptionPC / io_exceptionInst / io_coreid, output, 32/32/64/32/8, meaning event payload to the sink.

Function
REQ-011 SHALL accept an event when evt_valid and evt_ready are both high; evt_ready = FIFO not full.
REQ-012 SHALL discard, not enqueue, an accepted event whose evt_interrupt and evt_exception are both zero.
REQ-013 SHALL, when both evt_interrupt and evt_exception are nonzero, enqueue the interrupt code and force the exception field to zero (interrupt priority).
REQ-014 SHALL enqueue qualifying events in order into a DEPTH-entry FIFO with wrapping read/write pointers and a count of width clog2(DEPTH)+1.
REQ-015 SHALL drive enable = io_valid = FIFO not empty, with payload from the head entry, registered (no combinational path from evt_* to io_*).
REQ-016 SHALL pop the head when io_valid and sink_ready are both high; payload SHALL stay stable while io_valid and not sink_ready.
REQ-017 SHALL give minimum latency of one cycle: event accepted in cycle N is presented in cycle N+1 if the FIFO was empty.
REQ-018 SHALL, on simultaneous push and pop when full, keep evt_ready low (no push); when empty, no bypass (push only).
REQ-019 SHALL, on simultaneous push and pop when neither full nor empty, keep count unchanged.
REQ-020 SHALL drive io_coreid = COREID constantly.

Reset
REQ-021 SHALL, on reset assertion at any time, clear pointers and count immediately, dropping queued events.
REQ-022 SHALL hold enable=0, io_valid=0, io_* payload=0, evt_ready=0 while reset is low.
REQ-023 SHALL raise evt_ready on the first clock edge after reset deasserts.

Configuration
REQ-024 SHALL, with DIFFTEST_ARCH_EVENT_PERF_EN defined, add output perf_evt_cnt (32 bits), counting popped events, saturating at 0xFFFFFFFF, reset to 0.
REQ-025 SHALL, without DIFFTEST_ARCH_EVENT_PERF_EN, omit perf_evt_cnt and its counter entirely; all other behaviour identical.

Structure
REQ-026 SHALL place typedef arch_event_t (interrupt, exception, pc, inst; 160 bits) and the width constants in package difftest_arch_event_pkg.
REQ-027 SHALL implement storage in sub-module difftest_arch_event_fifo (generic DEPTH x arch_event_t, push/pop/full/empty).

Verification
REQ-028 SHALL cover: single event irq=0, exc=2, pc=0x80000004, inst=0x00000073, sink_ready=1 -> io_valid high next cycle with those values, io_coreid=COREID.
REQ-029 SHALL cover: evt_valid with irq=0, exc=0 -> evt_ready=1, io_valid stays 0.
REQ-030 SHALL cover: irq=7, exc=2 together -> presented io_interrupt=7, io_exception=0.
REQ-031 SHALL cover: sink_ready=0, push 5 events with DEPTH=4 -> evt_ready low after 4th; release sink_ready -> 4 events emitted in order, then 5th.
REQ-032 SHALL cover: reset asserted with 3 queued events -> io_valid=0 immediately; no stale event after release.
REQ-033 SHALL cover (PERF_EN): 10 pops -> perf_evt_cnt=10; preload 0xFFFFFFFF -> stays 0xFFFFFFFF after a pop.
